// File: rtl/sram_pkg.sv
// Shared types and helpers for the multi-port SRAM with clear engine.
package sram_pkg;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_t;

  // Widest word byte_merge can handle; callers widen/narrow around it.
  localparam int MAX_W = 1024;

  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int lane_cnt(input int w, input int b);
    return w / b;
  endfunction

  // Enabled lanes take new_w, disabled lanes keep old_w.
  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_W-1:0] be,
                                                  input int byte_w);
    logic [MAX_W-1:0] r;
    int lane;
    r = old_w;
    for (int b = 0; b < MAX_W; b++) begin
      lane = b / byte_w;
      if (be[lane[9:0]]) r[b[9:0]] = new_w[b[9:0]];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// Clear engine: sweeps every address once, driving the array write port.
module sram_clear_fsm
  import sram_pkg::*;
#(
  parameter int NUM_WORDS      = 131072,
  parameter int CLEAR_ON_RESET = 1,
  parameter int AW             = addr_w(NUM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam clr_state_t    RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
  localparam logic [AW-1:0] LAST      = AW'(NUM_WORDS - 1);

  clr_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          busy_q;

  // Next state: clear_req only matters in IDLE; the sweep ends after the last word.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (clear_req) begin
        state_d = CLEAR;
        addr_d  = '0;
      end
      CLEAR: if (addr_q == LAST) begin
        state_d = IDLE;
        addr_d  = '0;
      end else begin
        addr_d  = addr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, address and registered busy; reset restarts the sweep from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      addr_q  <= '0;
      busy_q  <= (RST_STATE == CLEAR);
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      busy_q  <= (state_d == CLEAR);
    end
  end

  assign busy     = busy_q;
  assign clr_we   = busy_q;
  assign clr_addr = addr_q;

endmodule

// File: rtl/sram_mp_clr.sv
// Multi-read-port, single-write-port SRAM with byte enables, write-first
// bypass and a sequential clear engine in place of an array reset.
module sram_mp_clr
  import sram_pkg::*;
#(
  parameter int                    NUM_WORDS      = 131072,
  parameter int                    WORD_WIDTH     = 32,
  parameter int                    BYTE_WIDTH     = 8,
  parameter int                    NUM_READ_PORTS = 2,
  parameter logic [WORD_WIDTH-1:0] RESET_VAL      = '0,
  parameter int                    CLEAR_ON_RESET = 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 clear_req,
  output logic                                                 busy,
  input  logic                                                 we,
  input  logic [$clog2(NUM_WORDS)-1:0]                         write_addr,
  input  logic [WORD_WIDTH-1:0]                                write_data,
  input  logic [WORD_WIDTH/BYTE_WIDTH-1:0]                     write_be,
  input  logic [NUM_READ_PORTS-1:0]                            re,
  input  logic [NUM_READ_PORTS-1:0][$clog2(NUM_WORDS)-1:0]     read_addr,
  output logic [NUM_READ_PORTS-1:0][WORD_WIDTH-1:0]            read_data,
  output logic [NUM_READ_PORTS-1:0]                            read_valid
);

  localparam int            AW    = $clog2(NUM_WORDS);
  localparam int            LANES = lane_cnt(WORD_WIDTH, BYTE_WIDTH);
  localparam logic [AW:0]   NW_L  = NUM_WORDS[AW:0];

  if (WORD_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $fatal(1, "WORD_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (WORD_WIDTH > MAX_W) begin : g_too_wide
    $fatal(1, "WORD_WIDTH exceeds byte_merge capacity");
  end
  if (NUM_WORDS < 2) begin : g_bad_depth
    $fatal(1, "NUM_WORDS must be >= 2");
  end
  if (NUM_READ_PORTS < 1) begin : g_bad_ports
    $fatal(1, "NUM_READ_PORTS must be >= 1");
  end

  logic [WORD_WIDTH-1:0] mem [NUM_WORDS];

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  sram_clear_fsm #(
    .NUM_WORDS      (NUM_WORDS),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .AW             (AW)
  ) u_clr (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // A user write counts only in IDLE and only for an in-range address.
  logic user_wr;
  assign user_wr = we && !busy && ({1'b0, write_addr} < NW_L);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;
  logic [LANES-1:0]      wr_be;
  logic [MAX_W-1:0]      wr_merged;

  // Write mux: the clear engine owns the port while sweeping.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_addr;
    wr_data = RESET_VAL;
    wr_be   = '1;
    if (clr_we) begin
      wr_en = 1'b1;
    end else if (user_wr) begin
      wr_en   = 1'b1;
      wr_addr = write_addr;
      wr_data = write_data;
      wr_be   = write_be;
    end
    wr_merged = byte_merge(MAX_W'(mem[wr_addr]), MAX_W'(wr_data), MAX_W'(wr_be), BYTE_WIDTH);
  end

  // Array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_merged[WORD_WIDTH-1:0];
  end

  for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_rd
    logic [AW-1:0]         ra;
    logic                  in_range;
    logic [MAX_W-1:0]      byp;
    logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_vld_q, rd_vld_d;

    assign ra       = read_addr[i];
    assign in_range = ({1'b0, ra} < NW_L);

    // Registered read with write-first bypass of the byte-merged word.
    always_comb begin
      rd_data_d = rd_data_q;
      rd_vld_d  = 1'b0;
      byp       = byte_merge(MAX_W'(mem[ra]), MAX_W'(write_data), MAX_W'(write_be), BYTE_WIDTH);
      if (re[i] && !busy) begin
        rd_vld_d = 1'b1;
        if (!in_range)                       rd_data_d = RESET_VAL;
        else if (user_wr && write_addr == ra) rd_data_d = byp[WORD_WIDTH-1:0];
        else                                 rd_data_d = mem[ra];
      end
    end

    // Read port output registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q <= RESET_VAL;
        rd_vld_q  <= 1'b0;
      end else begin
        rd_data_q <= rd_data_d;
        rd_vld_q  <= rd_vld_d;
      end
    end

    assign read_data[i]  = rd_data_q;
    assign read_valid[i] = rd_vld_q;
  end

endmodule

// File: doc/sram_mp_clr.md
Name: sram_mp_clr

Overview:
Parametrised multi-read-port, single-write-port word memory with synchronous (registered) reads, per-byte write enables and write-first bypass. Replaces whole-array reset with a sequential clear engine that sweeps every address to RESET_VAL. Used as the general storage primitive for buffers and tables in the datapath.

Parameters:
NUM_WORDS, 131072, number of words; must be >= 2.
WORD_WIDTH, 32, bits per word; must be a multiple of BYTE_WIDTH.
BYTE_WIDTH, 8, bits per write-enable lane.
NUM_READ_PORTS, 2, number of independent read ports; must be >= 1.
RESET_VAL, '0, value written by the clear engine; WORD_WIDTH bits.
CLEAR_ON_RESET, 1, 1 = start a clear sweep on reset release; 0 = contents undefined after reset.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
clear_req  in  1  pulse: start a clear sweep
busy  out  1  clear sweep in progress
we  in  1  write enable
write_addr  in  $clog2(NUM_WORDS)  write address
write_data  in  WORD_WIDTH  write data
write_be  in  WORD_WIDTH/BYTE_WIDTH  byte-lane enables
re  in  NUM_READ_PORTS  per-port read enable
read_addr  in  NUM_READ_PORTS x $clog2(NUM_WORDS)  per-port read address
read_data  out  NUM_READ_PORTS x WORD_WIDTH  per-port registered read data
read_valid  out  NUM_READ_PORTS  per-port read data valid

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: read_valid = 0; read_data = RESET_VAL on all ports; clear address = 0.
- Reset state: CLEAR when CLEAR_ON_RESET = 1, IDLE otherwise. busy = 1 in CLEAR, 0 in IDLE.
- The memory array itself is not reset.
- FSM states: IDLE and CLEAR. busy = (state == CLEAR).
- IDLE -> CLEAR: on the clock edge where clear_req = 1. The clear address is loaded with 0.
- CLEAR: each cycle writes RESET_VAL to the clear address (all lanes), then increments it.
- CLEAR -> IDLE: on the edge that writes address NUM_WORDS-1. busy is high for exactly NUM_WORDS cycles.
- clear_req while in CLEAR is ignored: no restart, no queuing.
- rst asserted mid-sweep aborts it. On release, with CLEAR_ON_RESET = 1, the sweep restarts from address 0.
- Writes, IDLE only: when we = 1, each lane k with write_be[k] = 1 stores write_data[k*BYTE_WIDTH +: BYTE_WIDTH]. Other lanes keep their contents. write_be = 0 is a no-op.
- Writes while busy are dropped silently.
- Reads, IDLE only: re[i] = 1 at edge t gives read_data[i] = mem[read_addr[i]] and read_valid[i] = 1 after edge t. Latency is 1 cycle.
- re[i] = 0: read_valid[i] = 0 next cycle and read_data[i] holds its previous value.
- re[i] while busy: read_valid[i] = 0 and read_data[i] holds.
- Read-during-write, same address, same edge: write-first. The returned word is the byte-merged new data (enabled lanes new, disabled lanes old). This applies independently on every port.
- Different ports may read the same address in the same cycle; all return identical data.
- clear_req and we asserted together in IDLE: the write is performed, then the sweep starts next cycle and overwrites it.
- clear_req and re asserted together in IDLE: the read completes normally, with read_valid = 1 next cycle.
- Out-of-range addresses (NUM_WORDS not a power of 2): writes ignored; reads return RESET_VAL with read_valid = 1.
- Elaboration-time checks: WORD_WIDTH % BYTE_WIDTH == 0, NUM_WORDS >= 2, NUM_READ_PORTS >= 1. A violation is a fatal error.

Decomposition:
- Shared package sram_pkg:
  - clr_state_t enum (IDLE, CLEAR).
  - Function byte_merge(old, new, be), shared by the array write and the bypass path.
  - Localparam helpers for address width and lane count.
- Sub-module sram_clear_fsm: owns the state, clear address counter and busy. It outputs the clear write strobe and address to the array write mux.
- The top module holds the array, the write mux and a generate loop of read ports.

Test Plan:
1. NUM_WORDS = 16, CLEAR_ON_RESET = 1; hold rst for 3 cycles, then release -> busy = 1 for exactly 16 cycles; afterwards read addresses 0..15 on both ports -> all 0, read_valid = 1 one cycle after each re.
2. IDLE; write 0xDEADBEEF to address 3 with be = 4'b1111; next cycle re[0] at address 3 -> following cycle read_data[0] = 0xDEADBEEF, read_valid[0] = 1; with re = 0 the data holds and read_valid drops.
3. Address 3 holds 0xDEADBEEF; write 0x12345678 with be = 4'b0011 -> read returns 0xDEAD5678; a write with be = 0 leaves 0xDEAD5678.
4. Same edge: write 0xCAFEF00D to address 5 (full be), port 0 reads address 5, port 1 reads address 6 (holding 0x11) -> port 0 returns 0xCAFEF00D, port 1 returns 0x11; repeat with be = 4'b1000 over old 0 -> 0xCA000000.
5. clear_req in IDLE together with a write of 0x55 to address 2 -> busy for 16 cycles; a we to address 4 and re during busy are dropped (read_valid stays 0); all addresses read 0 afterwards.
6. Assert rst when the clear address is 7 -> busy stays 1, read_valid = 0, read_data = RESET_VAL; after release busy lasts 16 full cycles; clear_req pulsed during the sweep does not extend it.
